lcd_responder: RTL and testbench
================================

Name: lcd_responder

Overview:
- Synthesizable HD44780-compatible character-LCD responder. It is the module end of the 8-bit LCD bus that lcd_bridge drives.
- Decodes RS/RW/EN/DATA transactions, keeps a 2x40 DDRAM image, an address counter and display-control flags, models the busy flag, and answers status and data reads.
- Used as an on-chip LCD mirror (display contents are readable through a host port) and as the bus model in the stopwatch LCD benches.

Parameters:
- BUSY_CYCLES, 2000, iCLK cycles of busy after an ordinary instruction or data write (40 us at 50 MHz).
- LONG_CYCLES, 82000, iCLK cycles of busy after Clear Display or Return Home (1.64 ms). Must be at least 80.

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST_N  in  1  synchronous active-low reset.
- LCD_DATA  in  8  bus data from the initiator.
- LCD_RS  in  1  0 = instruction/status, 1 = data.
- LCD_RW  in  1  0 = write, 1 = read.
- LCD_EN  in  1  enable strobe.
- oLCD_DATA  out  8  read-back data.
- oLCD_OE  out  1  read-back drive enable; external tristate.
- iRD_ADDR  in  7  host mirror index, 0..79 (line*40 + column).
- oRD_DATA  out  8  DDRAM[iRD_ADDR], registered, 1-cycle latency.
- oBUSY  out  1  busy flag.
- oAC  out  7  address counter.
- oDISP_CTRL  out  3  {D, C, B}.
- oENTRY  out  2  {I/D, S}.
- oDROP  out  1  1-cycle pulse when a write is ignored because busy.

Behaviour:
- Synchronisation: RS, RW, EN and DATA each pass through a 2-flop synchroniser. A write strobe is a synchronised EN falling edge with RW=0; DATA and RS are sampled on that edge.
- Reads: while synchronised EN=1 and RW=1, oLCD_OE=1.
  - RS=0 returns {oBUSY, oAC}.
  - RS=1 returns DDRAM[AC]. If AC is invalid, returns 0x20.
  - On the EN fall that ends a data read, AC steps per I/D.
  - oLCD_OE=0 at all other times.
- Valid DDRAM addresses: 0x00–0x27 (index AC) and 0x40–0x67 (index AC−0x40+40).
- AC increment: 0x27→0x40, 0x67→0x00, otherwise +1 mod 128.
- AC decrement: 0x40→0x27, 0x00→0x67, otherwise −1 mod 128.
- Data write (RS=1): writes DDRAM[AC] only if AC is valid, then AC steps per I/D. If S=1 the step is also reported as a shift; no display offset is modelled. Loads BUSY_CYCLES.
- Instruction write (RS=0): decoded by highest set bit.
  - 0x80|a: AC=a. Any value is accepted; writes to invalid AC are discarded.
  - 0x40|x (CGRAM): accepted, no storage; data writes while CGRAM is selected are discarded and AC is unchanged.
  - 0x20: function set; stored internally, otherwise no effect.
  - 0x10|SC<<3|RL<<2: SC=0 moves AC right/left, using the increment/decrement rules; SC=1 is a no-op.
  - 0x08|DCB: sets oDISP_CTRL.
  - 0x04|ID<<1|S: sets oENTRY.
  - 0x02/0x03: AC=0; loads LONG_CYCLES.
  - 0x01: AC=0, I/D=1, clear sweep starts; loads LONG_CYCLES.
  - 0x00: ignored.
  - Every accepted instruction other than 0x02/0x03 and 0x01 loads BUSY_CYCLES.
- Clear sweep: writes 0x20 to one DDRAM index per cycle, 0..79. It finishes in 80 cycles, always within the busy window.
- Busy: oBUSY=1 while the busy down-counter is non-zero, or while a sweep is active.
  - A write strobe seen while busy is dropped: oDROP pulses, no state change.
  - Reads are always served while busy.
- Reset (iRST_N=0 at an iCLK edge):
  - Outputs: oBUSY=1, oAC=0, oDISP_CTRL=000, oENTRY=10, oLCD_OE=0, oDROP=0, oRD_DATA=0x20.
  - Synchronisers are cleared.
  - On release, the sweep clears DDRAM and oBUSY falls 80 cycles later.
  - Reset asserted mid-sweep or mid-busy restarts the sweep.
  - EN edges while in reset are ignored.
- Simultaneous events:
  - A host iRD_ADDR read of the index being written returns the old value this cycle and the new value next cycle.
  - iRD_ADDR > 79 returns 0x20.

Optional Feature:
- Macro: LCD_RESPONDER_FOUR_BIT_EN.
- When defined: a function set with DL=0 enters 4-bit mode.
  - Each write takes two strobes on DATA[7:4], high nibble first.
  - Reads return the high nibble on the first strobe and the low nibble on the second, on oLCD_DATA[7:4].
  - A nibble toggle flop tracks the phase and is cleared by reset.
  - A function set with DL=1 returns to 8-bit mode.
  - Busy is loaded on the second nibble only.
- When undefined: DL is stored and ignored; the bus is always 8-bit.

Decomposition:
- Package lcd_pkg holds:
  - instruction opcode masks;
  - the address constants LINE0_END=0x27, LINE1_BASE=0x40, LINE1_END=0x67, DDRAM_DEPTH=80;
  - the space character 0x20;
  - the AC next-address function.
- One sub-module, lcd_ddram: 80x8 register file with one write port (sweep/data mux outside), one combinational bus-read port and one registered host-read port.

Test Plan:
- Reset then idle: oBUSY=1 for 80 cycles, then 0. All 80 host reads return 0x20. oAC=0, oENTRY=10.
- Write 0x80|0x27, then data 'A','B': DDRAM index 39='A', index 40='B', oAC=0x41. Each write busy for 2000 cycles.
- Entry 0x04 (decrement), AC=0x00, write 'Z': index 0='Z', oAC=0x67.
- Write a strobe 100 cycles after a data write: oDROP pulses once, DDRAM and AC unchanged.
- Status read during Clear: oLCD_DATA[7]=1 and AC=0 until cycle 82000, then 0. DDRAM is all 0x20.
- FOUR_BIT_EN: function set 0x20, then nibbles 0x8,0x5: AC=0x05. Nibbles 0x4,0x1 store 0x41 at index 5.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, opcode masks and address helpers for the LCD responder
package lcd_pkg;

  // DDRAM address map: line 0 at 0x00..0x27, line 1 at 0x40..0x67
  localparam logic [6:0] LINE0_END   = 7'h27;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam logic [6:0] LINE1_END   = 7'h67;
  localparam int         DDRAM_DEPTH = 80;
  localparam logic [7:0] SPACE_CHAR  = 8'h20;

  // Instruction opcodes, decoded by highest set bit
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } lcd_state_e;

  // Address counter step with the line wrap rules (inc=1 increments)
  function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == LINE0_END)      r = LINE1_BASE;
      else if (ac == LINE1_END) r = 7'h00;
      else                      r = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)     r = LINE0_END;
      else if (ac == 7'h00)     r = LINE1_END;
      else                      r = ac - 7'd1;
    end
    return r;
  endfunction

  function automatic logic ac_valid(input logic [6:0] ac);
    return (ac <= LINE0_END) || ((ac >= LINE1_BASE) && (ac <= LINE1_END));
  endfunction

  // Line 1 addresses map to indices 40..79
  function automatic logic [6:0] ac_index(input logic [6:0] ac);
    return (ac >= LINE1_BASE) ? (ac - 7'd24) : ac;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// rtl/lcd_ddram.sv - 80x8 display RAM with one write port, a bus read port and a registered host port
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [6:0] baddr_i,
  output logic [7:0] bdata_o,
  input  logic [6:0] haddr_i,
  output logic [7:0] hdata_o
);

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic [7:0] hdata_q;

  // Single write port; contents are initialised by the clear sweep, not by reset
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < 7'(DDRAM_DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Host mirror read: registered, old data on a same-cycle write
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hdata_q <= SPACE_CHAR;
    end else if (haddr_i < 7'(DDRAM_DEPTH)) begin
      hdata_q <= mem_q[haddr_i];
    end else begin
      hdata_q <= SPACE_CHAR;
    end
  end

  // Bus read is combinational so status/data reads see the current image
  always_comb begin
    bdata_o = SPACE_CHAR;
    if (baddr_i < 7'(DDRAM_DEPTH)) begin
      bdata_o = mem_q[baddr_i];
    end
  end

  assign hdata_o = hdata_q;

endmodule

// File: rtl/lcd_responder.sv
// rtl/lcd_responder.sv - HD44780-style LCD bus responder; LCD_RESPONDER_FOUR_BIT_EN adds 4-bit bus mode
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 2000,
  parameter int unsigned LONG_CYCLES = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_OE,
  input  logic [6:0] iRD_ADDR,
  output logic [7:0] oRD_DATA,
  output logic       oBUSY,
  output logic [6:0] oAC,
  output logic [2:0] oDISP_CTRL,
  output logic [1:0] oENTRY,
  output logic       oDROP
);

  localparam int unsigned CNT_MAX = (LONG_CYCLES > BUSY_CYCLES) ? LONG_CYCLES : BUSY_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(LONG_CYCLES);

  // {RS, RW, EN, DATA} through two flops, plus the previous EN for edge detect
  logic [10:0] bus_s1_q, bus_s2_q;
  logic        en_prev_q;
  logic        rs_s, rw_s, en_s;
  logic [7:0]  data_s;

  lcd_state_e       state_q, state_d;
  logic [6:0]       sweep_idx_q, sweep_idx_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [6:0]       ac_q, ac_d;
  logic [2:0]       disp_q, disp_d;
  logic [1:0]       entry_q, entry_d;
  logic [2:0]       func_q, func_d;
  logic             cgram_q, cgram_d;
  logic             drop_q, drop_d;

`ifdef LCD_RESPONDER_FOUR_BIT_EN
  logic       four_bit_q, four_bit_d;
  logic       nib_q, nib_d;
  logic [3:0] hi_q, hi_d;
`endif

  logic       busy;
  logic       en_fall, wr_strobe, rd_end, rd_step, exec;
  logic [7:0] cmd;
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] bus_rd_data;
  logic [7:0] full_rd_byte, rd_byte;

  assign rs_s   = bus_s2_q[10];
  assign rw_s   = bus_s2_q[9];
  assign en_s   = bus_s2_q[8];
  assign data_s = bus_s2_q[7:0];

  assign en_fall   = en_prev_q & ~en_s;
  assign wr_strobe = en_fall & ~rw_s;
  assign rd_end    = en_fall & rw_s & rs_s;
  assign busy      = (busy_cnt_q != '0) || (state_q == ST_SWEEP);

  // State register: synchronisers and all control state; reset restarts the sweep
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      bus_s1_q    <= '0;
      bus_s2_q    <= '0;
      en_prev_q   <= 1'b0;
      state_q     <= ST_SWEEP;
      sweep_idx_q <= 7'd0;
      busy_cnt_q  <= '0;
      ac_q        <= 7'd0;
      disp_q      <= 3'b000;
      entry_q     <= 2'b10;
      func_q      <= 3'b100;
      cgram_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      bus_s1_q    <= {LCD_RS, LCD_RW, LCD_EN, LCD_DATA};
      bus_s2_q    <= bus_s1_q;
      en_prev_q   <= en_s;
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      busy_cnt_q  <= busy_cnt_d;
      ac_q        <= ac_d;
      disp_q      <= disp_d;
      entry_q     <= entry_d;
      func_q      <= func_d;
      cgram_q     <= cgram_d;
      drop_q      <= drop_d;
    end
  end

`ifdef LCD_RESPONDER_FOUR_BIT_EN
  // Nibble-mode flags: bus width, nibble phase and the held high nibble
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      four_bit_q <= 1'b0;
      nib_q      <= 1'b0;
      hi_q       <= 4'h0;
    end else begin
      four_bit_q <= four_bit_d;
      nib_q      <= nib_d;
      hi_q       <= hi_d;
    end
  end
`endif

  // Next state: clear sweep, busy timer, instruction/data decode and read-side AC stepping
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    busy_cnt_d  = (busy_cnt_q != '0) ? (busy_cnt_q - CNT_W'(1)) : busy_cnt_q;
    ac_d        = ac_q;
    disp_d      = disp_q;
    entry_d     = entry_q;
    func_d      = func_q;
    cgram_d     = cgram_q;
    drop_d      = wr_strobe & busy;
    mem_we      = 1'b0;
    mem_waddr   = sweep_idx_q;
    mem_wdata   = SPACE_CHAR;
    exec        = wr_strobe & ~busy;
    cmd         = data_s;
    rd_step     = rd_end;
`ifdef LCD_RESPONDER_FOUR_BIT_EN
    four_bit_d  = four_bit_q;
    nib_d       = nib_q;
    hi_d        = hi_q;
    if (four_bit_q) begin
      cmd     = {hi_q, data_s[7:4]};
      rd_step = rd_end & nib_q;
      if (exec || (en_fall & rw_s)) nib_d = ~nib_q;
      if (exec && !nib_q) hi_d = data_s[7:4];
      exec    = exec & nib_q;
    end
`endif

    if (state_q == ST_SWEEP) begin
      mem_we = 1'b1;
      if (sweep_idx_q == 7'(DDRAM_DEPTH - 1)) state_d = ST_IDLE;
      else                                    sweep_idx_d = sweep_idx_q + 7'd1;
    end

    if (exec) begin
      if (rs_s) begin
        busy_cnt_d = BUSY_LOAD;
        if (!cgram_q) begin
          if (ac_valid(ac_q)) begin
            mem_we    = 1'b1;
            mem_waddr = ac_index(ac_q);
            mem_wdata = cmd;
          end
          ac_d = ac_next(ac_q, entry_q[1]);
        end
      end else if ((cmd & OP_SET_DDRAM) != 8'h00) begin
        ac_d       = cmd[6:0];
        cgram_d    = 1'b0;
        busy_cnt_d = BUSY_LOAD;
      end else if ((cmd & OP_SET_CGRAM) != 8'h00) begin
        cgram_d    = 1'b1;
        busy_cnt_d = BUSY_LOAD;
      end else if ((cmd & OP_FUNC_SET) != 8'h00) begin
        func_d     = cmd[4:2];
`ifdef LCD_RESPONDER_FOUR_BIT_EN
        four_bit_d = ~cmd[4];
`endif
        busy_cnt_d = BUSY_LOAD;
      end else if ((cmd & OP_SHIFT) != 8'h00) begin
        if (!cmd[3]) ac_d = ac_next(ac_q, cmd[2]);
        busy_cnt_d = BUSY_LOAD;
      end else if ((cmd & OP_DISP_CTRL) != 8'h00) begin
        disp_d     = cmd[2:0];
        busy_cnt_d = BUSY_LOAD;
      end else if ((cmd & OP_ENTRY) != 8'h00) begin
        entry_d    = cmd[1:0];
        busy_cnt_d = BUSY_LOAD;
      end else if ((cmd & OP_HOME) != 8'h00) begin
        ac_d       = 7'd0;
        cgram_d    = 1'b0;
        busy_cnt_d = LONG_LOAD;
      end else if ((cmd & OP_CLEAR) != 8'h00) begin
        ac_d        = 7'd0;
        cgram_d     = 1'b0;
        entry_d     = {1'b1, entry_q[0]};
        state_d     = ST_SWEEP;
        sweep_idx_d = 7'd0;
        busy_cnt_d  = LONG_LOAD;
      end
    end

    if (rd_step && !cgram_q) begin
      ac_d = ac_next(ac_q, entry_q[1]);
    end
  end

  // Bus read-back: status byte or DDRAM[AC], nibble-selected in 4-bit mode
  always_comb begin
    full_rd_byte = {busy, ac_q};
    if (rs_s) full_rd_byte = ac_valid(ac_q) ? bus_rd_data : SPACE_CHAR;
    rd_byte = full_rd_byte;
`ifdef LCD_RESPONDER_FOUR_BIT_EN
    if (four_bit_q) rd_byte = nib_q ? {full_rd_byte[3:0], 4'h0} : {full_rd_byte[7:4], 4'h0};
`endif
  end

  lcd_ddram u_ddram (
    .clk_i   (iCLK),
    .rst_ni  (iRST_N),
    .we_i    (mem_we & iRST_N),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .baddr_i (ac_index(ac_q)),
    .bdata_o (bus_rd_data),
    .haddr_i (iRD_ADDR),
    .hdata_o (oRD_DATA)
  );

  assign oLCD_OE    = en_s & rw_s;
  assign oLCD_DATA  = oLCD_OE ? rd_byte : 8'h00;
  assign oBUSY      = busy;
  assign oAC        = ac_q;
  assign oDISP_CTRL = disp_q;
  assign oENTRY     = entry_q;
  assign oDROP      = drop_q;

endmodule

// File: tb/tb_lcd_responder.sv
// tb/tb_lcd_responder.sv - directed table-driven bench for lcd_responder
module tb_lcd_responder;

  localparam int BUSY = 40;
  localparam int LONG = 300;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic       LCD_RS = 1'b0;
  logic       LCD_RW = 1'b0;
  logic       LCD_EN = 1'b0;
  logic [7:0] oLCD_DATA;
  logic       oLCD_OE;
  logic [6:0] iRD_ADDR = 7'd0;
  logic [7:0] oRD_DATA;
  logic       oBUSY;
  logic [6:0] oAC;
  logic [2:0] oDISP_CTRL;
  logic [1:0] oENTRY;
  logic       oDROP;

  lcd_responder #(.BUSY_CYCLES(BUSY), .LONG_CYCLES(LONG)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .oLCD_DATA(oLCD_DATA), .oLCD_OE(oLCD_OE),
    .iRD_ADDR(iRD_ADDR), .oRD_DATA(oRD_DATA), .oBUSY(oBUSY), .oAC(oAC),
    .oDISP_CTRL(oDISP_CTRL), .oENTRY(oENTRY), .oDROP(oDROP)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int drop_cnt = 0;
  always @(negedge iCLK) if (oDROP) drop_cnt = drop_cnt + 1;

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] img [80];

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] ac;
    logic [1:0] entry;
    logic [2:0] disp;
    int         len;
  } vec_t;
  vec_t tbl [21];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge iCLK);
    LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA = d; LCD_EN = 1'b1;
    repeat (4) @(negedge iCLK);
    LCD_EN = 1'b0;
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe);
    @(negedge iCLK);
    LCD_RS = rs; LCD_RW = 1'b1; LCD_EN = 1'b1;
    repeat (4) @(negedge iCLK);
    d = oLCD_DATA; oe = oLCD_OE;
    LCD_EN = 1'b0;
    repeat (4) @(negedge iCLK);
    LCD_RW = 1'b0;
  endtask

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge iCLK); #1;
      if (oBUSY) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output int t_fall);
    for (int i = 0; i < 2000; i++) begin
      if (!oBUSY) break;
      @(posedge iCLK); #1;
    end
    if (oBUSY) check("idle_timeout", 1, 0);
    t_fall = cyc;
  endtask

  task automatic wr_len(input logic rs, input logic [7:0] d, output int len);
    bit ok;
    int t0, t1;
    bus_write(rs, d);
    wait_rise(ok);
    len = 0;
    if (ok) begin
      t0 = cyc;
      wait_idle(t1);
      len = t1 - t0;
    end
  endtask

  task automatic host_read(input logic [6:0] a, output logic [7:0] d);
    @(negedge iCLK);
    iRD_ADDR = a;
    @(negedge iCLK);
    d = oRD_DATA;
  endtask

  task automatic check_image(input string name);
    int bad;
    logic [7:0] d;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      host_read(7'(i), d);
      if (d !== img[i]) begin
        if (bad == 0) $display("  image idx %0d got 0x%0h want 0x%0h", i, d, img[i]);
        bad++;
      end
    end
    check(name, bad, 0);
  endtask

  task automatic count_release(input string name);
    int n;
    n = 0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge iCLK); n++; #1;
      if (!oBUSY) break;
    end
    check(name, n, 80);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, t0, t1, d0;
    bit ok;
    logic [7:0] d;
    logic oe;

    tbl[0]  = '{1'b0, 8'hA7, 7'h27, 2'b10, 3'b000, BUSY};
    tbl[1]  = '{1'b1, 8'h41, 7'h40, 2'b10, 3'b000, BUSY};
    tbl[2]  = '{1'b1, 8'h42, 7'h41, 2'b10, 3'b000, BUSY};
    tbl[3]  = '{1'b0, 8'h0F, 7'h41, 2'b10, 3'b111, BUSY};
    tbl[4]  = '{1'b0, 8'h04, 7'h41, 2'b00, 3'b111, BUSY};
    tbl[5]  = '{1'b0, 8'h80, 7'h00, 2'b00, 3'b111, BUSY};
    tbl[6]  = '{1'b1, 8'h5A, 7'h67, 2'b00, 3'b111, BUSY};
    tbl[7]  = '{1'b0, 8'h14, 7'h00, 2'b00, 3'b111, BUSY};
    tbl[8]  = '{1'b0, 8'h10, 7'h67, 2'b00, 3'b111, BUSY};
    tbl[9]  = '{1'b0, 8'h18, 7'h67, 2'b00, 3'b111, BUSY};
    tbl[10] = '{1'b0, 8'h06, 7'h67, 2'b10, 3'b111, BUSY};
    tbl[11] = '{1'b0, 8'h30, 7'h67, 2'b10, 3'b111, BUSY};
    tbl[12] = '{1'b0, 8'hB0, 7'h30, 2'b10, 3'b111, BUSY};
    tbl[13] = '{1'b1, 8'h58, 7'h31, 2'b10, 3'b111, BUSY};
    tbl[14] = '{1'b0, 8'h40, 7'h31, 2'b10, 3'b111, BUSY};
    tbl[15] = '{1'b1, 8'h59, 7'h31, 2'b10, 3'b111, BUSY};
    tbl[16] = '{1'b0, 8'h85, 7'h05, 2'b10, 3'b111, BUSY};
    tbl[17] = '{1'b0, 8'h02, 7'h00, 2'b10, 3'b111, LONG};
    tbl[18] = '{1'b0, 8'h07, 7'h00, 2'b11, 3'b111, BUSY};
    tbl[19] = '{1'b0, 8'h00, 7'h00, 2'b11, 3'b111, 0};
    tbl[20] = '{1'b0, 8'h0C, 7'h00, 2'b11, 3'b100, BUSY};

    for (int i = 0; i < 80; i++) img[i] = 8'h20;

    // Reset values
    repeat (5) @(negedge iCLK);
    check("rst_busy", oBUSY, 1);
    check("rst_ac", oAC, 0);
    check("rst_disp", oDISP_CTRL, 0);
    check("rst_entry", oENTRY, 2);
    check("rst_oe", oLCD_OE, 0);
    check("rst_drop", oDROP, 0);
    check("rst_rd_data", oRD_DATA, 8'h20);

    count_release("sweep_busy_len");
    check_image("image_after_reset");
    host_read(7'd100, d);
    check("host_out_of_range", d, 8'h20);
    check("idle_oe", oLCD_OE, 0);

    // Instruction/data table
    for (int i = 0; i < 21; i++) begin
      wr_len(tbl[i].rs, tbl[i].d, len);
      check($sformatf("row%0d_busy_len", i), len, tbl[i].len);
      check($sformatf("row%0d_ac", i), oAC, tbl[i].ac);
      check($sformatf("row%0d_entry", i), oENTRY, tbl[i].entry);
      check($sformatf("row%0d_disp", i), oDISP_CTRL, tbl[i].disp);
    end
    img[39] = 8'h41; img[40] = 8'h42; img[0] = 8'h5A;
    check_image("image_after_table");

    // Bus reads: data read steps AC across the line boundary, status read
    wr_len(1'b0, 8'hA7, len);
    bus_read(1'b1, d, oe);
    check("rd_data_A", d, 8'h41);
    check("rd_oe", oe, 1);
    check("rd_ac_step", oAC, 7'h40);
    bus_read(1'b1, d, oe);
    check("rd_data_B", d, 8'h42);
    check("rd_ac_step2", oAC, 7'h41);
    bus_read(1'b0, d, oe);
    check("rd_status", d, 8'h41);
    check("oe_after_read", oLCD_OE, 0);
    wr_len(1'b0, 8'hB0, len);
    bus_read(1'b1, d, oe);
    check("rd_invalid_ac", d, 8'h20);
    check("rd_invalid_ac_step", oAC, 7'h31);

    // Write while busy is dropped
    wr_len(1'b0, 8'h85, len);
    bus_write(1'b1, 8'h43);
    wait_rise(ok);
    d0 = drop_cnt;
    bus_write(1'b1, 8'h44);
    wait_idle(t1);
    repeat (3) @(negedge iCLK);
    check("drop_pulses", drop_cnt - d0, 1);
    check("drop_ac", oAC, 7'h06);
    img[5] = 8'h43;

    // Host read of the index being written: old value, then new value
    @(negedge iCLK);
    iRD_ADDR = 7'd6;
    bus_write(1'b1, 8'h45);
    wait_rise(ok);
    check("host_same_cycle_old", oRD_DATA, 8'h20);
    @(posedge iCLK); #1;
    check("host_next_cycle_new", oRD_DATA, 8'h45);
    wait_idle(t1);
    img[6] = 8'h45;
    check_image("image_after_drop");

    // Clear display: status read while busy, long busy window, blank image
    bus_write(1'b0, 8'h01);
    wait_rise(ok);
    t0 = cyc;
    bus_read(1'b0, d, oe);
    check("clear_status_busy", d, 8'h80);
    wait_idle(t1);
    check("clear_busy_len", t1 - t0, LONG);
    bus_read(1'b0, d, oe);
    check("clear_status_idle", d, 8'h00);
    check("clear_entry", oENTRY, 2'b11);
    for (int i = 0; i < 80; i++) img[i] = 8'h20;
    check_image("image_after_clear");

    // Reset mid-busy with EN activity during reset
    d0 = drop_cnt;
    bus_write(1'b1, 8'h51);
    wait_rise(ok);
    @(negedge iCLK);
    iRST_N = 1'b0;
    LCD_RS = 1'b0; LCD_DATA = 8'h85; LCD_EN = 1'b1;
    repeat (4) @(negedge iCLK);
    LCD_EN = 1'b0;
    repeat (5) @(negedge iCLK);
    check("midrst_busy", oBUSY, 1);
    count_release("midrst_sweep_len");
    repeat (6) @(negedge iCLK);
    check("midrst_ac", oAC, 0);
    check("midrst_entry", oENTRY, 2'b10);
    check("midrst_disp", oDISP_CTRL, 0);
    check("midrst_no_drop", drop_cnt - d0, 0);
    check_image("image_after_midrst");

`ifdef LCD_RESPONDER_FOUR_BIT_EN
    wr_len(1'b0, 8'h20, len);
    check("fb_funcset_len", len, BUSY);
    wr_len(1'b0, 8'h80, len);
    check("fb_first_nibble_len", len, 0);
    wr_len(1'b0, 8'h50, len);
    check("fb_second_nibble_len", len, BUSY);
    check("fb_ac", oAC, 7'h05);
    wr_len(1'b1, 8'h40, len);
    wr_len(1'b1, 8'h10, len);
    check("fb_data_ac", oAC, 7'h06);
    host_read(7'd5, d);
    check("fb_data_stored", d, 8'h41);
    wr_len(1'b0, 8'h80, len);
    wr_len(1'b0, 8'h50, len);
    bus_read(1'b1, d, oe);
    check("fb_read_hi", d, 8'h40);
    bus_read(1'b1, d, oe);
    check("fb_read_lo", d, 8'h10);
    check("fb_read_ac", oAC, 7'h06);
`else
    wr_len(1'b0, 8'h20, len);
    check("fs_len", len, BUSY);
    wr_len(1'b0, 8'h85, len);
    check("fs_ac", oAC, 7'h05);
    wr_len(1'b1, 8'h41, len);
    check("fs_data_ac", oAC, 7'h06);
    host_read(7'd5, d);
    check("fs_data_stored", d, 8'h41);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
